// File: rtl/heater_pkg.sv
// Shared types and default constants for the heater plant and its controller.
package heater_pkg;

    localparam int TEMP_W_DEF   = 12;
    localparam int AMBIENT_DEF  = 200;
    localparam int TEMP_MAX_DEF = 1000;

    // Temperature in 0.1 degC steps at the default width.
    typedef logic [TEMP_W_DEF-1:0] temp_t;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        RESP,
        DEAD
    } sens_state_e;

endpackage

// File: rtl/heater_thermal_model.sv
// Tick divider plus saturating first-order integrator that turns the heater
// drive into a modelled temperature.
module heater_thermal_model #(
    parameter int TEMP_W    = 12,
    parameter int AMBIENT   = 200,
    parameter int TEMP_MAX  = 1000,
    parameter int HEAT_STEP = 3,
    parameter int COOL_STEP = 1,
    parameter int TICK_DIV  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              heat_on_i,
    output logic [TEMP_W-1:0] temp_o
);

    localparam int CNT_W   = $clog2(TICK_DIV);
    localparam int TEMP_W1 = TEMP_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [TEMP_W1-1:0] MAX_X    = TEMP_W1'(TEMP_MAX);
    localparam logic [TEMP_W1-1:0] AMB_X    = TEMP_W1'(AMBIENT);
    localparam logic [TEMP_W1-1:0] UP_X     = TEMP_W1'(HEAT_STEP);
    localparam logic [TEMP_W1-1:0] DN_X     = TEMP_W1'(COOL_STEP);
    localparam logic [TEMP_W-1:0]  MAX_T    = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0]  AMB_T    = TEMP_W'(AMBIENT);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TEMP_W-1:0]  temp_q, temp_d;
    logic [TEMP_W1-1:0] sum, diff;
    logic               tick;

    // The extra bit on sum/diff catches both overshoot and borrow, so the
    // clamp never sees a wrapped value.
    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
        sum    = {1'b0, temp_q} + UP_X;
        diff   = {1'b0, temp_q} - DN_X;
        temp_d = temp_q;
        if (tick) begin
            if (heat_on_i) begin
                temp_d = (sum > MAX_X) ? MAX_T : sum[TEMP_W-1:0];
            end else begin
                temp_d = (diff[TEMP_W] || (diff < AMB_X)) ? AMB_T : diff[TEMP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            temp_q <= AMB_T;
        end else begin
            cnt_q  <= cnt_d;
            temp_q <= temp_d;
        end
    end

    assign temp_o = temp_q;

endmodule

// File: rtl/heater_plant.sv
// Thermal plant and temperature-sensor responder with stuck/dead sensor
// fault injection, facing the heater controller's actuator/sensor port.
module heater_plant
    import heater_pkg::*;
#(
    parameter int TEMP_W    = TEMP_W_DEF,
    parameter int AMBIENT   = AMBIENT_DEF,
    parameter int TEMP_MAX  = TEMP_MAX_DEF,
    parameter int HEAT_STEP = 3,
    parameter int COOL_STEP = 1,
    parameter int TICK_DIV  = 10,
    parameter int SENSE_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              heat_on,
    input  logic              samp_req,
    output logic              samp_valid,
    output logic [TEMP_W-1:0] samp_temp,
    output logic              busy,
    input  logic              fault_stuck,
    input  logic              fault_dead,
    output logic [TEMP_W-1:0] temp_now
);

    if (!((AMBIENT <= TEMP_MAX) && (TEMP_MAX < (2 ** TEMP_W)))) begin : g_bad_range
        $error("heater_plant: need AMBIENT <= TEMP_MAX < 2**TEMP_W");
    end
    if ((TICK_DIV < 2) || (SENSE_LAT < 1)) begin : g_bad_timing
        $error("heater_plant: need TICK_DIV >= 2 and SENSE_LAT >= 1");
    end

    localparam int LAT_W = (SENSE_LAT > 1) ? $clog2(SENSE_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(SENSE_LAT - 1);
    localparam logic [TEMP_W-1:0] AMB_T    = TEMP_W'(AMBIENT);

    heater_thermal_model #(
        .TEMP_W   (TEMP_W),
        .AMBIENT  (AMBIENT),
        .TEMP_MAX (TEMP_MAX),
        .HEAT_STEP(HEAT_STEP),
        .COOL_STEP(COOL_STEP),
        .TICK_DIV (TICK_DIV)
    ) u_thermal (
        .clk      (clk),
        .reset    (reset),
        .heat_on_i(heat_on),
        .temp_o   (temp_now)
    );

    sens_state_e       state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [TEMP_W-1:0] cap_q, cap_d;
    logic [TEMP_W-1:0] frozen_q, frozen_d;
    logic [TEMP_W-1:0] stemp_q, stemp_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            cap_q    <= '0;
            frozen_q <= AMB_T;
            stemp_q  <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            cap_q    <= cap_d;
            frozen_q <= frozen_d;
            stemp_q  <= stemp_d;
        end
    end

    // samp_temp is loaded on the way into RESP so it is valid alongside
    // samp_valid and then simply holds until the next response.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        cap_d      = cap_q;
        stemp_d    = stemp_q;
        frozen_d   = fault_stuck ? frozen_q : temp_now;
        busy       = 1'b0;
        samp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (samp_req) begin
                    cap_d   = fault_stuck ? frozen_q : temp_now;
                    lat_d   = LAT_INIT;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                busy = 1'b1;
                if (lat_q == '0) begin
                    if (fault_dead) begin
                        state_d = DEAD;
                    end else begin
                        state_d = RESP;
                        stemp_d = cap_q;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                samp_valid = 1'b1;
                state_d    = IDLE;
            end
            DEAD: begin
                busy = 1'b1;
                if (!fault_dead) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign samp_temp = stemp_q;

endmodule

// File: tb/tb_heater_plant.sv
// Self-checking bench for heater_plant: directed scenarios plus random
// stimulus, all compared every cycle against a behavioural plant model.
module tb_heater_plant;
    import heater_pkg::*;

    localparam int TEMP_W    = 12;
    localparam int AMBIENT   = 200;
    localparam int TEMP_MAX  = 1000;
    localparam int HEAT_STEP = 3;
    localparam int COOL_STEP = 1;
    localparam int TICK_DIV  = 10;
    localparam int SENSE_LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic heat_on = 1'b0;
    logic samp_req = 1'b0;
    logic fault_stuck = 1'b0;
    logic fault_dead = 1'b0;
    logic samp_valid;
    logic busy;
    logic [TEMP_W-1:0] samp_temp;
    logic [TEMP_W-1:0] temp_now;

    int nCompared = 0;
    int nMismatched = 0;

    heater_plant #(
        .TEMP_W   (TEMP_W),
        .AMBIENT  (AMBIENT),
        .TEMP_MAX (TEMP_MAX),
        .HEAT_STEP(HEAT_STEP),
        .COOL_STEP(COOL_STEP),
        .TICK_DIV (TICK_DIV),
        .SENSE_LAT(SENSE_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .heat_on    (heat_on),
        .samp_req   (samp_req),
        .samp_valid (samp_valid),
        .samp_temp  (samp_temp),
        .busy       (busy),
        .fault_stuck(fault_stuck),
        .fault_dead (fault_dead),
        .temp_now   (temp_now)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Plant model: temperature from tick arithmetic, sensor as a countdown
    // to the response cycle with a dead flag.
    int  mTemp = AMBIENT;
    int  mPhase = 0;
    int  mFrozen = AMBIENT;
    int  mStemp = 0;
    int  mCap = 0;
    int  mRem = 0;
    bit  mValid = 1'b0;
    bit  mDead = 1'b0;
    bit  modelReady = 1'b0;

    always @(posedge clk) begin
        int  tOld;
        int  fOld;
        bit  vOld;
        tOld = mTemp;
        fOld = mFrozen;
        vOld = mValid;
        if (reset) begin
            mTemp = AMBIENT; mPhase = 0; mFrozen = AMBIENT; mStemp = 0;
            mCap = 0; mRem = 0; mValid = 1'b0; mDead = 1'b0;
        end else begin
            if (mPhase == TICK_DIV - 1) begin
                if (heat_on) mTemp = (tOld + HEAT_STEP > TEMP_MAX) ? TEMP_MAX : tOld + HEAT_STEP;
                else         mTemp = (tOld - COOL_STEP < AMBIENT)  ? AMBIENT  : tOld - COOL_STEP;
            end
            mPhase = (mPhase + 1) % TICK_DIV;
            if (!fault_stuck) mFrozen = tOld;
            mValid = 1'b0;
            if (mDead) begin
                if (!fault_dead) mDead = 1'b0;
            end else if (mRem > 0) begin
                if (mRem == 1) begin
                    if (fault_dead) mDead = 1'b1;
                    else begin mValid = 1'b1; mStemp = mCap; end
                end
                mRem--;
            end else if (!vOld && samp_req) begin
                mCap = fault_stuck ? fOld : tOld;
                mRem = SENSE_LAT;
            end
        end
        modelReady = 1'b1;
    end

    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("model_temp_now", 32'(temp_now), 32'(mTemp));
            checkOutput("model_samp_valid", 32'(samp_valid), 32'(mValid));
            checkOutput("model_busy", 32'(busy), 32'(mDead || (mRem > 0)));
            checkOutput("model_samp_temp", 32'(samp_temp), 32'(mStemp));
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit h, input bit r, input bit s, input bit d);
        heat_on = h;
        samp_req = r;
        fault_stuck = s;
        fault_dead = d;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        stepCycles(10);
        reset = 1'b0;
    endtask

    task automatic waitValid(input int budget, output int cycles, output bit got,
                             output logic [TEMP_W-1:0] val);
        got = 1'b0;
        cycles = 0;
        val = '0;
        while (!got && cycles < budget) begin
            stepCycles(1);
            samp_req = 1'b0;
            cycles++;
            if (samp_valid === 1'b1) begin
                got = 1'b1;
                val = samp_temp;
            end
        end
    endtask

    initial begin
        int pulses, bad, pulseAt, cyc;
        bit got;
        logic [TEMP_W-1:0] val, pulseVal;

        // Reset state and idle plant
        doReset();
        checkOutput("reset_temp_now", 32'(temp_now), AMBIENT);
        checkOutput("reset_samp_temp", 32'(samp_temp), 0);
        checkOutput("reset_samp_valid", 32'(samp_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        pulses = 0; bad = 0;
        for (int i = 0; i < 200; i++) begin
            stepCycles(1);
            if (samp_valid !== 1'b0) pulses++;
            if (temp_now !== 12'(AMBIENT)) bad++;
        end
        checkOutput("idle_temp_dev_cycles", bad, 0);
        checkOutput("idle_pulses", pulses, 0);

        // Heating then cooling
        doReset();
        heat_on = 1'b1;
        stepCycles(100);
        checkOutput("heat100_temp", 32'(temp_now), 230);
        heat_on = 1'b0;
        stepCycles(50);
        checkOutput("cool50_temp", 32'(temp_now), 225);

        // Saturation at the ceiling
        doReset();
        heat_on = 1'b1;
        stepCycles(2660);
        checkOutput("tick266_temp", 32'(temp_now), 998);
        stepCycles(10);
        checkOutput("tick267_temp", 32'(temp_now), TEMP_MAX);
        stepCycles(1330);
        checkOutput("sat_hold_temp", 32'(temp_now), TEMP_MAX);

        // Latency and ignored request while busy
        doReset();
        heat_on = 1'b1;
        stepCycles(100);
        samp_req = 1'b1;
        pulses = 0; pulseAt = -1; pulseVal = '0;
        for (int k = 1; k <= 20; k++) begin
            stepCycles(1);
            samp_req = (k == 2);
            if (k == 1) checkOutput("req_busy_next", 32'(busy), 1);
            if (samp_valid === 1'b1) begin
                pulses++;
                pulseAt = k;
                pulseVal = samp_temp;
            end
        end
        checkOutput("lat_pulse_count", pulses, 1);
        checkOutput("lat_pulse_cycle", pulseAt, SENSE_LAT + 1);
        checkOutput("lat_pulse_temp", 32'(pulseVal), 230);

        // Stuck sensor
        doReset();
        heat_on = 1'b1;
        stepCycles(201);
        fault_stuck = 1'b1;
        stepCycles(100);
        samp_req = 1'b1;
        waitValid(20, cyc, got, val);
        checkOutput("stuck_got_resp", 32'(got), 1);
        checkOutput("stuck_samp_temp", 32'(val), 260);
        checkOutput("stuck_temp_now", 32'(temp_now), 290);

        // Dead sensor, recovery, reset mid-conversion
        doReset();
        fault_dead = 1'b1;
        samp_req = 1'b1;
        stepCycles(1);
        samp_req = 1'b0;
        pulses = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            stepCycles(1);
            if (samp_valid !== 1'b0) pulses++;
            if (busy !== 1'b1) bad++;
        end
        checkOutput("dead_pulses", pulses, 0);
        checkOutput("dead_not_busy_cycles", bad, 0);
        fault_dead = 1'b0;
        stepCycles(1);
        checkOutput("dead_release_busy", 32'(busy), 0);
        samp_req = 1'b1;
        waitValid(20, cyc, got, val);
        checkOutput("after_dead_got_resp", 32'(got), 1);
        checkOutput("after_dead_latency", cyc, SENSE_LAT + 1);
        checkOutput("after_dead_temp", 32'(val), AMBIENT);
        stepCycles(2);
        samp_req = 1'b1;
        stepCycles(2);
        samp_req = 1'b0;
        reset = 1'b1;
        stepCycles(1);
        checkOutput("abort_busy", 32'(busy), 0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycles(1);
            if (samp_valid !== 1'b0) pulses++;
        end
        checkOutput("abort_pulses", pulses, 0);

        // Random traffic checked by the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            heat_on  = ($urandom_range(0, 99) < 60);
            samp_req = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 2) fault_stuck = ~fault_stuck;
            if ($urandom_range(0, 99) < 2) fault_dead = ~fault_dead;
            reset = ($urandom_range(0, 999) < 3);
            stepCycles(1);
        end
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        stepCycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/heater_plant.md
Name: heater_plant

Overview:
- Synthesizable thermal-plant and temperature-sensor responder. It sits at the far end of the heater controller's actuator/sensor interface.
- Consumes the controller's `heat_on` drive and integrates it into a modelled temperature.
- Answers the controller's sample requests with a delayed temperature reading.
- Provides fault injection (stuck sensor, dead sensor) so the controller's `error` / `err_clear` path can be exercised in simulation and on FPGA.

Parameters:
- TEMP_W, 12, width of temperature value (unsigned, 1 LSB = 0.1 degC)
- AMBIENT, 200, reset and floor temperature
- TEMP_MAX, 1000, saturation ceiling
- HEAT_STEP, 3, increment per tick while heating
- COOL_STEP, 1, decrement per tick while not heating
- TICK_DIV, 10, clock cycles per thermal tick (>=2)
- SENSE_LAT, 4, cycles from accepted request to response (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- heat_on  in  1  heater drive from controller
- samp_req  in  1  single-cycle sample request from controller
- samp_valid  out  1  one-cycle pulse, response ready
- samp_temp  out  TEMP_W  sampled temperature, valid with samp_valid
- busy  out  1  conversion in progress
- fault_stuck  in  1  sensor freezes: responses return the last pre-fault temperature
- fault_dead  in  1  sensor never responds: requests accepted, no samp_valid
- temp_now  out  TEMP_W  live model temperature (debug/bench observation)

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - temp_now = AMBIENT, samp_temp = 0, samp_valid = 0, busy = 0.
  - Tick counter = 0; state = IDLE; frozen register = AMBIENT.
- Thermal model:
  - Tick counter counts 0..TICK_DIV-1 and wraps. The tick fires on the cycle the counter equals TICK_DIV-1.
  - On a tick with heat_on=1: temp = min(temp+HEAT_STEP, TEMP_MAX).
  - On a tick with heat_on=0: temp = max(temp-COOL_STEP, AMBIENT).
  - Compute the sum/difference one bit wider than TEMP_W before saturating; there is no wrap-around.
  - heat_on is sampled only on the tick cycle.
- Frozen register:
  - Tracks temp_now every cycle while fault_stuck=0.
  - Holds its value while fault_stuck=1.
- Sensor FSM:
  - IDLE: samp_req=1 latches the capture value (temp_now, or the frozen register if fault_stuck=1), loads the latency counter with SENSE_LAT-1, sets busy=1, goes to CONVERT.
  - CONVERT: decrement the counter. At 0, go to RESP if fault_dead=0, else go to DEAD.
  - RESP (1 cycle): samp_valid=1, samp_temp=captured value, busy=0, go to IDLE.
  - DEAD: busy stays 1 until fault_dead deasserts, then go to IDLE with no response.
- Latency: req at cycle N -> samp_valid at cycle N+SENSE_LAT+1. The captured value is temp_now as registered at cycle N.
- Boundary conditions:
  - samp_req while busy (CONVERT/RESP/DEAD) is ignored and not queued.
  - samp_req coincident with a tick captures the pre-tick temperature.
  - fault_dead asserted mid-conversion takes effect at the counter-zero decision.
  - samp_temp holds its last value between responses.
  - Reset mid-conversion aborts it: no samp_valid is issued.
- Width check: AMBIENT <= TEMP_MAX < 2**TEMP_W, enforced by an elaboration-time assertion.

Decomposition:
- Package heater_pkg:
  - Sensor FSM state enum typedef (IDLE, CONVERT, RESP, DEAD).
  - Temperature typedef `temp_t`, of width TEMP_W.
  - Default constants AMBIENT / TEMP_MAX, shared with the heater controller.
- One sub-module, heater_thermal_model: the tick divider plus saturating integrator, producing temp_now.
- The sensor FSM stays in the top module.

Test Plan:
1. Reset 10 cycles, heat_on=0, wait 200 cycles -> temp_now stays 200 throughout; samp_valid never asserted.
2. heat_on=1 for 100 cycles from reset release -> temp_now = 230 (10 ticks x 3). Then heat_on=0 for 50 cycles -> 225.
3. heat_on=1 held 4000 cycles -> temp_now reaches 1000 at tick 267 and holds; no overflow.
4. Request at cycle N with temp_now=230 -> samp_valid pulse at N+5 with samp_temp=230. A second samp_req at N+2 is ignored, giving only one pulse.
5. Heat to 260, assert fault_stuck, keep heating 100 cycles, request -> samp_temp=260 while temp_now=290.
6. fault_dead=1, request -> busy stays 1 with no samp_valid for 50 cycles. Drop fault_dead -> busy=0 next cycle. A new request responds normally. Reset asserted mid-conversion -> no pulse, busy=0.
